// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial receive path.
package serial_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam logic LINE_IDLE            = 1'b1;
   localparam logic START_LEVEL          = 1'b0;
   localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; RESET_VAL sets the level
// both flops take while rst_i is high.
module sync_2ff
   import serial_pkg::*;
#(
   parameter logic RESET_VAL = LINE_IDLE
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_port.sv
// Serial link receiver: start/WIDTH data/stop frames into a CPU input port.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the PARITY_ERR flag.
module serial_rx_port
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int WIDTH        = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             SERIAL_IN,
   input  logic             RD_STROBE,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             VALID,
   output logic             OVERRUN,
   output logic             FRAME_ERR,
`ifdef SERIAL_RX_PARITY_EN
   output logic             PARITY_ERR,
`endif
   output logic             BUSY
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

   logic             rx_s;
   rx_state_t        state_q, state_d;
   logic [CW-1:0]    baud_q, baud_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;
   logic             armed_q, armed_d;
   logic             byte_ok;
`ifdef SERIAL_RX_PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             perr_q, perr_d;
`endif

   sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
      .clk_i (CLK),
      .rst_i (CLR),
      .d_i   (SERIAL_IN),
      .q_o   (rx_s)
   );

   // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;
      armed_d = armed_q | (rx_s == LINE_IDLE);
      byte_ok = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = perr_q;
      if (RD_STROBE) perr_d = 1'b0;
`endif
      if (RD_STROBE) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
         ferr_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // A break leaves armed_q low until the line has been seen idle again.
            if (armed_q && rx_s == START_LEVEL) begin
               state_d = START;
               baud_d  = '0;
            end
         end
         START: begin
            if (baud_q == HALF_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = (rx_s == START_LEVEL) ? DATA : IDLE;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d         = '0;
               shift_d[bit_q] = rx_s;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         PARITY: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = '0;
               par_bad_d = (rx_s != ^shift_q);
               state_d   = STOP;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
`endif
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = IDLE;
               if (rx_s == LINE_IDLE) begin
                  byte_ok = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
                  armed_d = 1'b0;
               end
`ifdef SERIAL_RX_PARITY_EN
               if (par_bad_q) begin
                  perr_d  = 1'b1;
                  byte_ok = 1'b0;
               end
`endif
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte landing in the same cycle as the CPU's read wins without flagging overrun.
      if (byte_ok) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         if (valid_q && !RD_STROBE) ovr_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         armed_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         armed_q <= armed_d;
`ifdef SERIAL_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign DATA_OUT  = data_q;
   assign VALID     = valid_q;
   assign OVERRUN   = ovr_q;
   assign FRAME_ERR = ferr_q;
   assign BUSY      = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
   assign PARITY_ERR = perr_q;
`endif

endmodule
